// File: rtl/sevenseg_pkg.sv
// rtl/sevenseg_pkg.sv - shared constants, types and helpers for seven-segment scan decoding
package sevenseg_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-high gfedcba patterns; the array index is the displayed hex value.
  localparam logic [6:0] SEG_DECODE [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    HELD     = 2'd2
  } scan_state_t;

  // True when exactly one active-low anode is driven.
  function automatic logic one_anode_low(input logic [NUM_DIGITS-1:0] an);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) n++;
    end
    return (n == 1);
  endfunction

  // Index of the low anode; only meaningful when one_anode_low() holds.
  function automatic logic [2:0] low_anode_index(input logic [NUM_DIGITS-1:0] an);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - active-high segment pattern to hex value lookup
module seg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] value,
  output logic       hit,
  output logic       blank
);

  // Table search; blank is reported separately because it is not a table entry.
  always_comb begin
    value = 4'h0;
    hit   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == SEG_DECODE[i]) begin
        value = 4'(i);
        hit   = 1'b1;
      end
    end
    blank = (pattern == SEG_BLANK);
  end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// rtl/seven_seg_scan_decoder.sv - rebuilds eight hex digits from multiplexed display lines
module seven_seg_scan_decoder
  import sevenseg_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  an,
  input  logic [6:0]  seg,
  input  logic        dp,
  output logic [31:0] digits,
  output logic [7:0]  dp_out,
  output logic [7:0]  blank,
  output logic [7:0]  digit_err,
  output logic        frame_done,
  output logic [7:0]  frame_count,
  output logic        scan_lost
);

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_SETTLE = CNT_W'(SETTLE_CYCLES);
  localparam logic [WD_W-1:0]  WD_MAX     = WD_W'(TIMEOUT_CYCLES);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);

  // Sample layout {an[7:0], seg[6:0], dp}; all-ones is the "nothing driven" state.
  logic [15:0]      samp;
  logic [15:0]      prev;
  scan_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [WD_W-1:0]  wd;
  logic [7:0]       seen;

  logic             valid;
  logic             stable;
  logic             changed;
  logic             capture;
  logic [2:0]       idx;
  logic [7:0]       idx_mask;
  logic [6:0]       pattern;
  logic [3:0]       dec_value;
  logic             dec_hit;
  logic             dec_blank;

  assign valid    = one_anode_low(samp[15:8]);
  assign changed  = (samp != prev);
  assign stable   = valid && !changed;
  assign idx      = low_anode_index(samp[15:8]);
  assign idx_mask = 8'h01 << idx;
  assign pattern  = ~samp[7:1];
  // Capture fires on the first stable sample after the count has reached the settle length.
  assign capture  = (state == SETTLING) && stable && (cnt == CNT_SETTLE);

  seg_pattern_decode u_decode (
    .pattern (pattern),
    .value   (dec_value),
    .hit     (dec_hit),
    .blank   (dec_blank)
  );

  // Input stage: current and previous sample of the raw display lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      samp <= 16'hFFFF;
      prev <= 16'hFFFF;
    end else begin
      samp <= {an, seg, dp};
      prev <= samp;
    end
  end

  // Settle FSM: a digit must hold still for the settle window before it is captured.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (valid) begin
            state <= SETTLING;
            cnt   <= CNT_ONE;
          end
        end
        SETTLING: begin
          if (!valid) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (!stable) begin
            cnt <= CNT_ONE;
          end else if (cnt == CNT_SETTLE) begin
            state <= HELD;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (changed) begin
            if (valid) begin
              state <= SETTLING;
              cnt   <= CNT_ONE;
            end else begin
              state <= IDLE;
              cnt   <= '0;
            end
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Per-digit result registers, written only by a capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits    <= '0;
      dp_out    <= '0;
      blank     <= 8'hFF;
      digit_err <= '0;
    end else if (capture) begin
      digits[4*idx +: 4] <= dec_hit ? dec_value : 4'h0;
      blank[idx]         <= !dec_hit && dec_blank;
      digit_err[idx]     <= !dec_hit && !dec_blank;
      dp_out[idx]        <= ~samp[0];
    end
  end

  // Frame tracking and scan watchdog; a capture always wins over a same-cycle timeout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen        <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      wd          <= '0;
      scan_lost   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        wd        <= '0;
        scan_lost <= 1'b0;
        if ((seen | idx_mask) == 8'hFF) begin
          seen        <= '0;
          frame_done  <= 1'b1;
          frame_count <= frame_count + 8'd1;
        end else begin
          seen <= seen | idx_mask;
        end
      end else if (wd != WD_MAX) begin
        wd <= wd + 1'b1;
        if (wd == WD_LAST) begin
          scan_lost <= 1'b1;
          seen      <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// tb/tb_seven_seg_scan_decoder.sv - scoreboard bench for seven_seg_scan_decoder
module tb_seven_seg_scan_decoder;

  localparam int S = 8;
  localparam int T = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  an  = 8'hFF;
  logic [6:0]  seg = 7'h7F;
  logic        dp  = 1'b1;
  logic [31:0] digits;
  logic [7:0]  dp_out, blank, digit_err, frame_count;
  logic        frame_done, scan_lost;

  seven_seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg), .dp(dp),
    .digits(digits), .dp_out(dp_out), .blank(blank), .digit_err(digit_err),
    .frame_done(frame_done), .frame_count(frame_count), .scan_lost(scan_lost)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [6:0] tbl [0:15] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int         cyc;
    int         idx;
    logic [3:0] val;
    logic       blk;
    logic       err;
    logic       dpv;
  } cap_t;

  cap_t q[$];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // Drive one display state for dwell cycles; queue the capture it must produce.
  task automatic drive(input logic [7:0] a, input logic [6:0] pat, input logic d, input int dwell);
    cap_t e;
    int   lows;
    int   li;
    an  = a;
    seg = ~pat;
    dp  = d;
    lows = 0;
    li   = 0;
    for (int i = 0; i < 8; i++) begin
      if (!a[i]) begin
        lows++;
        li = i;
      end
    end
    if (lows == 1 && dwell >= S + 1) begin
      e.cyc = cyc + S + 2;
      e.idx = li;
      e.val = 4'h0;
      e.blk = (pat == 7'h00);
      e.err = !e.blk;
      e.dpv = ~d;
      for (int v = 0; v < 16; v++) begin
        if (tbl[v] == pat) begin
          e.val = 4'(v);
          e.err = 1'b0;
        end
      end
      q.push_back(e);
    end
    repeat (dwell) @(posedge clk);
    #1;
  endtask

  // Reference model, advanced once per cycle and compared against every output.
  logic [31:0] m_digits;
  logic [7:0]  m_dp, m_blank, m_err, m_seen, m_fc;
  logic        m_fd, m_lost;
  int          m_wd;

  always @(negedge clk) begin
    if (rst) begin
      m_digits = '0; m_dp = '0; m_blank = 8'hFF; m_err = '0;
      m_seen = '0; m_fc = '0; m_fd = 1'b0; m_lost = 1'b0; m_wd = 0;
      q.delete();
    end else if (q.size() > 0 && q[0].cyc == cyc) begin
      cap_t e;
      e = q.pop_front();
      m_digits[4*e.idx +: 4] = e.val;
      m_blank[e.idx] = e.blk;
      m_err[e.idx]   = e.err;
      m_dp[e.idx]    = e.dpv;
      m_wd   = 0;
      m_lost = 1'b0;
      m_seen[e.idx] = 1'b1;
      if (m_seen == 8'hFF) begin
        m_seen = '0;
        m_fd   = 1'b1;
        m_fc   = m_fc + 8'd1;
      end else begin
        m_fd = 1'b0;
      end
    end else begin
      m_fd = 1'b0;
      if (m_wd < T) begin
        m_wd++;
        if (m_wd == T) begin
          m_lost = 1'b1;
          m_seen = '0;
        end
      end
    end
    check("digits", digits, m_digits);
    check("dp_out", {24'h0, dp_out}, {24'h0, m_dp});
    check("blank", {24'h0, blank}, {24'h0, m_blank});
    check("digit_err", {24'h0, digit_err}, {24'h0, m_err});
    check("frame_done", {31'h0, frame_done}, {31'h0, m_fd});
    check("frame_count", {24'h0, frame_count}, {24'h0, m_fc});
    check("scan_lost", {31'h0, scan_lost}, {31'h0, m_lost});
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Static digit
    drive(8'hFE, 7'h5B, 1'b1, 20);

    // Two full scans showing 1..8, second with DP lit on odd digits
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) begin
        drive(~(8'h01 << i), tbl[i + 1], (r == 1 && (i % 2) == 1) ? 1'b0 : 1'b1, 16);
      end
    end

    // Every table entry
    for (int i = 0; i < 16; i++) begin
      drive(~(8'h01 << (i % 8)), tbl[i], 1'b1, 16);
    end

    // Dwell boundary: S cycles ignored, S+1 captured
    drive(8'hF7, tbl[9], 1'b1, S);
    drive(8'hF7, tbl[10], 1'b1, S + 1);

    // Ghost rejection
    drive(8'hFB, tbl[8], 1'b1, 3);
    drive(8'hFB, tbl[1], 1'b1, 16);

    // Undecodable pattern, blank digit, two anodes low
    drive(8'hDF, 7'h01, 1'b1, 16);
    drive(8'hBF, 7'h00, 1'b0, 16);
    drive(8'hFC, tbl[5], 1'b1, 20);

    // Watchdog: three digits, silence, then partial and full scans
    drive(8'hFE, tbl[3], 1'b1, 16);
    drive(8'hFD, tbl[4], 1'b1, 16);
    drive(8'hFB, tbl[5], 1'b1, 16);
    drive(8'hFF, 7'h00, 1'b1, 60);
    for (int i = 3; i < 8; i++) drive(~(8'h01 << i), tbl[i + 6], 1'b1, 16);
    for (int i = 0; i < 8; i++) drive(~(8'h01 << i), tbl[15 - i], 1'b1, 16);

    // Reset in the middle of a settle
    an  = 8'hEF;
    seg = ~tbl[12];
    dp  = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive(8'hEF, tbl[12], 1'b1, 20);
    drive(8'hFE, tbl[7], 1'b1, 16);

    check("sb_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
